if_id_queue: RTL and testbench

- Decode-side receiver of the instruction fetch stream: accepts {PC, Instr, PC_plus4} beats from the fetch stage and buffers them in a small FIFO.
- Presents the oldest beat to decode with a valid/ready handshake and back-pressures fetch when full.
- Discards all buffered beats when a control-flow redirect (branch taken, JAL or JALR) resolves.
- Sits between the fetch stage and the decode/register-read stage of the core.

---
 rtl/if_id_queue.sv | 123 ++++++++++++
 tb/tb_if_id_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// ============================================================================
// Module   : if_id_queue
// Brief    : IF/ID instruction-beat FIFO with valid/ready handshake and
//            redirect flush. Optional perf counters under IFQ_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_queue #(
    parameter int              DEPTH     = 4,
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_instr,
    input  logic [XLEN-1:0]          in_pc_plus4,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_instr,
    output logic [XLEN-1:0]          out_pc_plus4,
    input  logic                     redirect,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
`ifdef IFQ_PERF_EN
    output logic [31:0]              perf_full_cycles,
    output logic [31:0]              perf_flushes,
`endif
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] mem_pc_q    [DEPTH];
    logic [XLEN-1:0] mem_instr_q [DEPTH];
    logic [XLEN-1:0] mem_pc4_q   [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic push;
    logic pop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = count_q;

    // A redirect cancels any handshake in the same cycle.
    assign push = in_valid  && in_ready  && !redirect;
    assign pop  = out_valid && out_ready && !redirect;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked by empty.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_pc_q[wr_ptr_q]    <= in_pc;
            mem_instr_q[wr_ptr_q] <= in_instr;
            mem_pc4_q[wr_ptr_q]   <= in_pc_plus4;
        end
    end

    assign out_pc       = empty ? '0        : mem_pc_q[rd_ptr_q];
    assign out_instr    = empty ? NOP_INSTR : mem_instr_q[rd_ptr_q];
    assign out_pc_plus4 = empty ? '0        : mem_pc4_q[rd_ptr_q];

`ifdef IFQ_PERF_EN
    logic [31:0] perf_full_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_full_q  <= '0;
            perf_flush_q <= '0;
        end else begin
            if (full && in_valid && (perf_full_q != '1))
                perf_full_q <= perf_full_q + 32'd1;
            if (redirect && (perf_flush_q != '1))
                perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_full_cycles = perf_full_q;
    assign perf_flushes     = perf_flush_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_queue.sv
// ============================================================================
// Module   : tb_if_id_queue
// Brief    : Directed + randomized bench for if_id_queue against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_id_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam logic [31:0] NOP = 32'h00000013;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_pc;
    logic [31:0]     in_instr;
    logic [31:0]     in_pc_plus4;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_pc;
    logic [31:0]     out_instr;
    logic [31:0]     out_pc_plus4;
    logic            redirect;
    logic [2:0]      count;
    logic            full;
    logic            empty;
`ifdef IFQ_PERF_EN
    logic [31:0]     perf_full_cycles;
    logic [31:0]     perf_flushes;
`endif

    if_id_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .NOP_INSTR(NOP)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .in_pc_plus4  (in_pc_plus4),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_pc_plus4 (out_pc_plus4),
        .redirect     (redirect),
        .count        (count),
        .full         (full),
`ifdef IFQ_PERF_EN
        .perf_full_cycles (perf_full_cycles),
        .perf_flushes     (perf_flushes),
`endif
        .empty        (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
    } beat_t;

    beat_t       q[$];
    int unsigned m_full_cycles;
    int unsigned m_flushes;
    int          n_pass;
    int          n_total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_beat(input logic [31:0] pc);
        in_pc       = pc;
        in_instr    = 32'h00500093 + (pc << 5);
        in_pc_plus4 = pc + 32'd4;
    endtask

    // Model the FIFO rules, then clock and move to #1 after the edge.
    task automatic tick();
        beat_t b;
        bit    m_full;
        m_full = (q.size() == DEPTH);
        if (!reset) begin
            q.delete();
            m_full_cycles = 0;
            m_flushes     = 0;
        end else begin
            if (m_full && in_valid && m_full_cycles != 32'hFFFFFFFF) m_full_cycles++;
            if (redirect) begin
                q.delete();
                if (m_flushes != 32'hFFFFFFFF) m_flushes++;
            end else begin
                b.pc = in_pc; b.instr = in_instr; b.pc4 = in_pc_plus4;
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (in_valid && !m_full) q.push_back(b);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"},     32'(count),     32'(n));
        chk({tag, ".empty"},     32'(empty),     32'(n == 0));
        chk({tag, ".full"},      32'(full),      32'(n == DEPTH));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(n != DEPTH));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(n != 0));
        chk({tag, ".out_pc"},    out_pc,         (n != 0) ? q[0].pc    : 32'h0);
        chk({tag, ".out_instr"}, out_instr,      (n != 0) ? q[0].instr : NOP);
        chk({tag, ".out_pc4"},   out_pc_plus4,   (n != 0) ? q[0].pc4   : 32'h0);
`ifdef IFQ_PERF_EN
        chk({tag, ".perf_full"},  perf_full_cycles, m_full_cycles);
        chk({tag, ".perf_flush"}, perf_flushes,     m_flushes);
`endif
    endtask

    initial begin
        logic [31:0] prev_pc;
        n_pass = 0; n_total = 0;
        m_full_cycles = 0; m_flushes = 0;
        reset = 1'b0; in_valid = 1'b1; out_ready = 1'b0; redirect = 1'b0;
        set_beat(32'h0);

        // Reset with fetch active
        tick(); tick();
        check_all("reset");
        chk("reset.instr_const", out_instr, 32'h00000013);
        reset = 1'b1;

        // Fill to full, then offer a fifth beat that must stall
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_beat(32'(i * 4));
            tick();
            check_all("fill");
        end
        chk("fill.full_after4", 32'(full), 32'd1);
        set_beat(32'h10);
        tick(); check_all("stall");
        tick(); check_all("stall");
        chk("stall.head_pc", out_pc, 32'h0);

        // Drain in order
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain.order", out_pc, 32'(i * 4));
            tick();
            check_all("drain");
        end
        chk("drain.empty_instr", out_instr, 32'h00000013);

        // Streaming from empty: occupancy holds at 1, head lags input by one
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            prev_pc = 32'h100 + 32'(i * 4);
            set_beat(prev_pc);
            tick();
            check_all("stream");
            chk("stream.count1", 32'(count), 32'd1);
            chk("stream.lag", out_pc, prev_pc);
        end
        in_valid = 1'b0; tick(); check_all("stream_end");

        // Flush with three entries while pushing and popping
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_beat(32'h20 + 32'(i * 4));
            tick();
        end
        check_all("preflush");
        redirect = 1'b1; out_ready = 1'b1; set_beat(32'h40);
        tick();
        redirect = 1'b0;
        check_all("flush");
        chk("flush.count0", 32'(count), 32'd0);
        out_ready = 1'b0; set_beat(32'h80);
        tick();
        check_all("post_flush");
        chk("post_flush.head", out_pc, 32'h80);

        // Flush on empty queue
        in_valid = 1'b0; out_ready = 1'b1; tick();
        redirect = 1'b1; tick(); redirect = 1'b0;
        check_all("flush_empty");

        // Randomized traffic including rare redirects and resets
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            redirect  = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 99) != 0);
            set_beat($urandom & 32'hFFFFFFFC);
            tick();
            check_all("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
